// File: rtl/aff7seg_scan.sv
// aff7seg_scan: time-multiplexed NDIG-digit common-anode 7-segment driver.
// Double-buffered display word, per-digit enable/blink, leading-zero blanking, guard slot.
module aff7seg_scan #(
    parameter int NDIG         = 4,
    parameter int DIV          = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] val,
    input  logic [NDIG-1:0]   en,
    input  logic [NDIG-1:0]   blink,
    input  logic              lz,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              phase_q, phase_d;
    logic [4*NDIG-1:0] pval_q, pval_d, aval_q, aval_d;
    logic [NDIG-1:0]   pen_q, pen_d, aen_q, aen_d;
    logic [NDIG-1:0]   pbl_q, pbl_d, abl_q, abl_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_q, frame_d;

    logic              slot_end, bnd, dark;
    logic [NDIG:0]     zchain;
    logic [3:0]        cur;
    logic              cur_en, cur_bl, cur_lz;

    function automatic logic [6:0] enc7(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // zchain[i]: digits i..NDIG-1 are all zero or disabled
    always_comb begin
        zchain       = '0;
        zchain[NDIG] = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zchain[i] = zchain[i+1] &
                        (~aen_q[i] | (aval_q[4*i +: 4] == 4'h0));
        end
        cur    = 4'h0;
        cur_en = 1'b0;
        cur_bl = 1'b0;
        cur_lz = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                cur    = aval_q[4*i +: 4];
                cur_en = aen_q[i];
                cur_bl = abl_q[i];
                cur_lz = (i != 0) && zchain[i];
            end
        end
    end

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        bnd      = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (bnd) begin
            if (fcnt_q == FR_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        pval_d = load ? val : pval_q;
        pen_d  = load ? en : pen_q;
        pbl_d  = load ? blink : pbl_q;
        // active takes the pre-edge pending copy, so a coincident load waits a frame
        aval_d = bnd ? pval_q : aval_q;
        aen_d  = bnd ? pen_q : aen_q;
        abl_d  = bnd ? pbl_q : abl_q;

        dark = (cnt_q < GUARD_C) || !cur_en ||
               (phase_q && cur_bl) || (lz && cur_lz);
        seg_d = dark ? 7'b1111111 : enc7(cur);
        an_d  = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (!dark && idx_q == IW'(i)) begin
                an_d[i] = 1'b0;
            end
        end
        frame_d = bnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            pval_q  <= '0;
            pen_q   <= '0;
            pbl_q   <= '0;
            aval_q  <= '0;
            aen_q   <= '0;
            abl_q   <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            pval_q  <= pval_d;
            pen_q   <= pen_d;
            pbl_q   <= pbl_d;
            aval_q  <= aval_d;
            aen_q   <= aen_d;
            abl_q   <= abl_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_aff7seg_scan.sv
// tb_aff7seg_scan: directed literal checks plus randomized traffic
// compared every cycle against a time-arithmetic model of the scan.
module tb_aff7seg_scan;
    localparam int NDIG = 4;
    localparam int DIV  = 4;
    localparam int GRD  = 1;
    localparam int BF   = 2;
    localparam int FR   = NDIG * DIV;
    localparam int VW   = 4 * NDIG;

    localparam logic [6:0] ENC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic          lz = 1'b0;
    logic [VW-1:0] val = '0;
    logic [NDIG-1:0] en = '0;
    logic [NDIG-1:0] blink = '0;
    logic [6:0]    seg;
    logic [NDIG-1:0] an;
    logic          frame;

    aff7seg_scan #(
        .NDIG(NDIG), .DIV(DIV), .GUARD(GRD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .val(val),
        .en(en), .blink(blink), .lz(lz),
        .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: position in the scan is pure arithmetic on edges since reset.
    int              mk;
    logic [VW-1:0]   m_pv, m_av;
    logic [NDIG-1:0] m_pe, m_ae, m_pb, m_ab;
    logic [6:0]      e_seg = 7'h7f;
    logic [NDIG-1:0] e_an = '1;
    logic            e_frame = 1'b0;

    initial forever begin
        int c, d, nb;
        bit ph, drk, allz;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mk = 0;
            m_pv = '0; m_av = '0;
            m_pe = '0; m_ae = '0;
            m_pb = '0; m_ab = '0;
            e_seg = 7'h7f; e_an = '1; e_frame = 1'b0;
        end else begin
            c  = mk % DIV;
            d  = (mk / DIV) % NDIG;
            nb = mk / FR;
            ph = ((nb / BF) % 2) == 1;
            allz = 1'b1;
            for (int j = d; j < NDIG; j++)
                if (m_ae[j] && m_av[4*j +: 4] != 4'h0) allz = 1'b0;
            drk = (c < GRD) || !m_ae[d] || (ph && m_ab[d]) ||
                  (lz && d >= 1 && allz);
            e_seg = drk ? 7'h7f : ENC[m_av[4*d +: 4]];
            e_an = '1;
            if (!drk) e_an[d] = 1'b0;
            e_frame = ((mk + 1) % FR) == 0;
            if (e_frame) begin
                m_av = m_pv; m_ae = m_pe; m_ab = m_pb;
            end
            if (load) begin
                m_pv = val; m_pe = en; m_pb = blink;
            end
            mk++;
        end
    end

    int n_print = 0;
    initial forever begin
        @(negedge clk);
        if (chk) begin
            n_cmp++;
            if (seg !== e_seg || an !== e_an || frame !== e_frame) begin
                n_bad++;
                if (n_print < 30) begin
                    n_print++;
                    $display("FAIL model t=%0t: seg=%b an=%b frame=%b expected seg=%b an=%b frame=%b",
                             $time, seg, an, frame, e_seg, e_an, e_frame);
                end
            end
        end
    end

    logic [6:0]      gs [FR];
    logic [NDIG-1:0] ga [FR];

    task automatic grab();
        for (int j = 0; j < FR; j++) begin
            if (j > 0) @(negedge clk);
            gs[j] = seg;
            ga[j] = an;
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 4 * FR);
        check("frame_seen", 32'(frame), 32'(1));
    endtask

    task automatic do_load(input logic [VW-1:0] v, input logic [NDIG-1:0] e,
                           input logic [NDIG-1:0] b);
        val = v; en = e; blink = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_dig(input string nm, input int i, input bit lit,
                             input logic [6:0] s);
        logic [NDIG-1:0] ea;
        logic [6:0] es;
        ea = '1;
        es = 7'h7f;
        if (lit) begin
            ea[i] = 1'b0;
            es = s;
        end
        check({nm, "_an"}, 32'(ga[4*i+2]), 32'(ea));
        check({nm, "_seg"}, 32'(gs[4*i+2]), 32'(es));
    endtask

    task automatic dark_frames(input string nm, input int nf);
        int lit = 0;
        repeat (nf * FR) begin
            @(negedge clk);
            if (an !== '1 || seg !== 7'h7f) lit++;
        end
        check(nm, 32'(lit), 32'(0));
    endtask

    int n;
    bit blit [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_seg", 32'(seg), 32'(7'b1111111));
        check("rst_an", 32'(an), 32'(4'b1111));
        check("rst_frame", 32'(frame), 32'(0));
        chk = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        dark_frames("dark_after_reset", 3);

        wait_frame(n);
        do_load(16'h12AF, 4'hF, 4'h0);
        wait_frame(n);
        grab();
        check("guard_an", 32'(ga[1]), 32'(4'b1111));
        check("guard_seg", 32'(gs[1]), 32'(7'b1111111));
        check("d0_an", 32'(ga[2]), 32'(4'b1110));
        check("d0_seg", 32'(gs[2]), 32'(7'b0001110));
        check("d1_an", 32'(ga[6]), 32'(4'b1101));
        check("d1_seg", 32'(gs[6]), 32'(7'b0001000));
        check("d2_an", 32'(ga[10]), 32'(4'b1011));
        check("d2_seg", 32'(gs[10]), 32'(7'b0100100));
        check("d3_an", 32'(ga[14]), 32'(4'b0111));
        check("d3_seg", 32'(gs[14]), 32'(7'b1111001));
        wait_frame(n);
        check("frame_period", 32'(n), 32'(1));

        lz = 1'b1;
        do_load(16'h0050, 4'hF, 4'h0);
        wait_frame(n);
        grab();
        check_dig("lz50_d3", 3, 1'b0, 7'h7f);
        check_dig("lz50_d2", 2, 1'b0, 7'h7f);
        check_dig("lz50_d1", 1, 1'b1, 7'b0010010);
        check_dig("lz50_d0", 0, 1'b1, 7'b1000000);
        wait_frame(n);
        do_load(16'h0000, 4'hF, 4'h0);
        wait_frame(n);
        grab();
        check_dig("lz0_d0", 0, 1'b1, 7'b1000000);
        check_dig("lz0_d1", 1, 1'b0, 7'h7f);
        check_dig("lz0_d3", 3, 1'b0, 7'h7f);
        lz = 1'b0;
        wait_frame(n);
        grab();
        for (int i = 0; i < NDIG; i++)
            check_dig($sformatf("nolz_d%0d", i), i, 1'b1, 7'b1000000);

        wait_frame(n);
        do_load(16'h1111, 4'hF, 4'h0);
        do_load(16'h2222, 4'hF, 4'h0);
        repeat (4) @(negedge clk);
        check("buf_cur_an", 32'(an), 32'(4'b1101));
        check("buf_cur_seg", 32'(seg), 32'(7'b1000000));
        wait_frame(n);
        grab();
        for (int i = 0; i < NDIG; i++)
            check_dig($sformatf("buf2_d%0d", i), i, 1'b1, 7'b0100100);

        wait_frame(n);
        repeat (FR - 1) @(negedge clk);
        do_load(16'h3333, 4'hF, 4'h0);
        check("bnd_align", 32'(frame), 32'(1));
        grab();
        check_dig("bnd_old_d0", 0, 1'b1, 7'b0100100);
        check_dig("bnd_old_d3", 3, 1'b1, 7'b0100100);
        wait_frame(n);
        grab();
        check_dig("bnd_new_d0", 0, 1'b1, 7'b0110000);
        check_dig("bnd_new_d2", 2, 1'b1, 7'b0110000);

        wait_frame(n);
        do_load(16'h12AF, 4'hF, 4'h0);
        wait_frame(n);
        repeat (2 * DIV + 3) @(negedge clk);
        check("pre_rst_an", 32'(an), 32'(4'b1011));
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'(7'b1111111));
        check("arst_an", 32'(an), 32'(4'b1111));
        check("arst_frame", 32'(frame), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dark_frames("dark_after_arst", 3);
        check("rel_align", 32'(frame), 32'(1));

        do_load(16'h1234, 4'hF, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            wait_frame(n);
            grab();
            check_dig($sformatf("blink_f%0d_d0", f), 0, blit[f], 7'b0011001);
            check_dig($sformatf("blink_f%0d_d1", f), 1, 1'b1, 7'b0110000);
        end

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 1500) begin
                load = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                load = ($urandom_range(0, 11) == 0);
                if (load) begin
                    val = VW'($urandom);
                    en = NDIG'($urandom);
                    blink = NDIG'($urandom);
                    if ($urandom_range(0, 2) == 0) val = val & VW'(16'h00F0);
                end
                if ($urandom_range(0, 39) == 0) lz = ~lz;
            end
        end
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
